// File: rtl/mem_wr_buffer.sv
// mem_wr_buffer: store-path FIFO from the controller toward memory.
// Accepts address/data store requests, then drains them one at a time
// over a req/ack handshake, strictly in push order.
module mem_wr_buffer #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     Store,
    input  logic [ADDR_W-1:0]        Store_Addr,
    input  logic [DATA_W-1:0]        Store_Data,
    output logic                     Buf_Full,
    output logic                     Buf_Empty,
    output logic                     Overflow,
    output logic [$clog2(DEPTH):0]   Pending,
    output logic                     Mem_Wr_Req,
    output logic [ADDR_W-1:0]        Mem_Addr,
    output logic [DATA_W-1:0]        Mem_Wr_Data,
    input  logic                     Mem_Wr_Ack
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               req_q, req_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;

    logic [ADDR_W-1:0]  addr_mem_q [DEPTH];
    logic [DATA_W-1:0]  data_mem_q [DEPTH];

    logic               pop_c;
    logic               push_ok_c;
    logic               not_full_c;

    // Handshake qualifiers: a pop is an ack seen while a transfer is active
    always_comb begin
        not_full_c = (count_q != CNT_W'(DEPTH));
        pop_c      = (state_q == ST_REQ) && Mem_Wr_Ack;
        push_ok_c  = Store && (not_full_c || pop_c);
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        req_d    = req_q;
        addr_d   = addr_q;
        data_d   = data_q;

        if (push_ok_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else if (Store) begin
            ovf_d = 1'b1;
        end

        case ({push_ok_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    addr_d  = addr_mem_q[rd_ptr_q];
                    data_d  = data_mem_q[rd_ptr_q];
                end
            end
            ST_REQ: begin
                if (Mem_Wr_Ack) begin
                    state_d  = ST_IDLE;
                    req_d    = 1'b0;
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase

        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0) && (state_d == ST_IDLE);
    end

    // State and control registers
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            req_q    <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            req_q    <= req_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Entry storage; contents need no reset since count gates every read
    always_ff @(posedge Clk) begin
        if (push_ok_c) begin
            addr_mem_q[wr_ptr_q] <= Store_Addr;
            data_mem_q[wr_ptr_q] <= Store_Data;
        end
    end

    assign Buf_Full    = full_q;
    assign Buf_Empty   = empty_q;
    assign Overflow    = ovf_q;
    assign Pending     = count_q;
    assign Mem_Wr_Req  = req_q;
    assign Mem_Addr    = addr_q;
    assign Mem_Wr_Data = data_q;

endmodule
